dmem_bus_responder: RTL

- Target (responder) end of the core's data-memory bus: sits on the far side of the core's data memory interface and answers its address, enable, byte-enable and write-data signals.
- Provides a word-organised data RAM plus a small MMIO page:
  - tohost halt register
  - console TX FIFO with a valid/ready drain port
  - sticky error register
  - optional cycle counter
- Reads are same-cycle, because the single-cycle core consumes read data in the cycle it issues the address. All state changes commit on the clock edge.

---
 rtl/dmem_bus_responder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_bus_responder.sv
// ---------------------------------------------------------------------------
// dmem_bus_responder
//
// Target end of the core's data-memory bus. Answers address / enable /
// byte-enable / write-data with:
//   - a word-organised data RAM (DEPTH_WORDS x 32 bit, byte-lane writes)
//   - a 16-byte MMIO page at MMIO_BASE:
//       +0x0 TOHOST   write: halt <= 1, halt_code <= data; read: halt_code
//       +0x4 CONSOLE  write: push data[7:0]; read: {overflow, full, empty}
//       +0x8 CYCLE    free-running cycle counter (optional, else reads 0)
//       +0xC ERROR    read: {unmapped_write, unmapped_read}; write-1-to-clear
//
// Reads are combinational (the single-cycle core consumes read data in the
// cycle it issues the address) and always return the pre-edge state, so a
// read and a write in the same cycle see the old value. All state changes
// commit on the rising clock edge.
//
// Optional feature macro: DMEM_CYCLE_COUNTER_EN builds the 32-bit cycle
// counter behind +0x8. Without it +0x8 reads 0. Writes to +0x8 are always
// ignored and never flag an error.
//
// Ports:
//   clock             single clock, rising edge
//   reset             synchronous, active-high; wins over any bus access
//   bus_address       byte address from the core
//   bus_read_enable   read strobe
//   bus_write_enable  write strobe
//   bus_byte_enable   lane enables, bit i selects bits 8i+7:8i
//   bus_write_data    lane-aligned write data
//   bus_read_data     combinational read data, 0 when not reading
//   tx_valid          console FIFO head is valid
//   tx_data           console FIFO head byte (0 while empty)
//   tx_ready          consumer accepts the head
//   halt              tohost has been written since reset
//   halt_code         last value written to tohost
//
// Console drain handshake: a byte transfers on a rising edge where
// tx_valid and tx_ready are both high. tx_valid never depends on tx_ready,
// and tx_data holds the same head byte until that byte is transferred.
// A push lands in the FIFO at the edge, so tx_valid rises one cycle after
// a push into an empty FIFO (no bypass).
// ---------------------------------------------------------------------------
module dmem_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [3:0]  bus_byte_enable,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  // 33 bits so the byte size of the largest legal RAM still fits.
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] REG_TOHOST  = 2'd0;
  localparam logic [1:0] REG_CONSOLE = 2'd1;
  localparam logic [1:0] REG_CYCLE   = 2'd2;
  localparam logic [1:0] REG_ERROR   = 2'd3;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic          ram_sel;
  logic          mmio_sel;
  logic          unmapped;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;

  assign ram_sel  = ({1'b0, bus_address} < RAM_BYTES);
  // RAM takes priority should a configuration ever overlap the two regions.
  assign mmio_sel = !ram_sel && (bus_address[31:4] == MMIO_BASE[31:4]);
  assign unmapped = !ram_sel && !mmio_sel;
  assign reg_sel  = bus_address[3:2];
  assign word_idx = bus_address[AW+1:2];

  // Byte offset within a word plays no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus_address[1:0];

  // -------------------------------------------------------------------------
  // Data RAM (not cleared by reset)
  // -------------------------------------------------------------------------
  logic [31:0] ram [DEPTH_WORDS];
  logic        ram_we;

  assign ram_we = !reset && bus_write_enable && ram_sel;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_byte_enable[i]) begin
          ram[word_idx][8*i +: 8] <= bus_write_data[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Console TX FIFO
  // -------------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          overflow;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign tx_valid   = !fifo_empty;
  // Gate the head so tx_data reads 0 whenever nothing is queued.
  assign tx_data    = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
  assign pop        = tx_valid && tx_ready;
  assign push_req   = bus_write_enable && mmio_sel && (reg_sel == REG_CONSOLE);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      fifo_mem[wr_ptr] <= bus_write_data[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // TOHOST
  // -------------------------------------------------------------------------
  logic tohost_we;

  // Byte enables are deliberately ignored: any store to tohost halts.
  assign tohost_we = bus_write_enable && mmio_sel && (reg_sel == REG_TOHOST);

  always_ff @(posedge clock) begin
    if (reset) begin
      halt      <= 1'b0;
      halt_code <= 32'h0;
    end else if (tohost_we) begin
      halt      <= 1'b1;
      halt_code <= bus_write_data;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky error flags
  // -------------------------------------------------------------------------
  logic       unmapped_read;
  logic       unmapped_write;
  logic [1:0] err_clr;
  logic       err_rd_set;
  logic       err_wr_set;

  assign err_rd_set = bus_read_enable && unmapped;
  assign err_wr_set = bus_write_enable && unmapped;
  assign err_clr    = (bus_write_enable && mmio_sel && (reg_sel == REG_ERROR))
                      ? bus_write_data[1:0] : 2'b00;

  // Set is OR-ed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      unmapped_read  <= 1'b0;
      unmapped_write <= 1'b0;
    end else begin
      unmapped_read  <= err_rd_set | (unmapped_read  & ~err_clr[0]);
      unmapped_write <= err_wr_set | (unmapped_write & ~err_clr[1]);
    end
  end

  // -------------------------------------------------------------------------
  // Optional cycle counter
  // -------------------------------------------------------------------------
  logic [31:0] cycle_value;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_count;

  // Wraps naturally from 0xFFFF_FFFF to 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count <= 32'h0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  assign cycle_value = cycle_count;
`else
  assign cycle_value = 32'h0;
`endif

  // -------------------------------------------------------------------------
  // Read mux: pre-edge state only, so read-during-write returns old data
  // -------------------------------------------------------------------------
  always_comb begin
    bus_read_data = 32'h0;
    if (bus_read_enable) begin
      if (ram_sel) begin
        bus_read_data = ram[word_idx];
      end else if (mmio_sel) begin
        case (reg_sel)
          REG_TOHOST:  bus_read_data = halt_code;
          REG_CONSOLE: bus_read_data = {29'h0, overflow, fifo_full, fifo_empty};
          REG_CYCLE:   bus_read_data = cycle_value;
          REG_ERROR:   bus_read_data = {30'h0, unmapped_write, unmapped_read};
          default:     bus_read_data = 32'h0;
        endcase
      end
    end
  end

endmodule
